// File: rtl/prng_generator.sv
// Bank of NUM parallel 32-bit Fibonacci LFSR lanes (taps 32,22,2,1).
// Lane i seeds from seed_arr + i + 1, so every lane starts non-zero on a distinct sequence.
// q is the XOR of all lane states. lanes exposes each raw lane register.
// period_done pulses on the step where lane 0 returns to its captured seed.
module prng_generator #(
  parameter int unsigned N   = 32,
  parameter int unsigned NUM = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NUM-1:0]   seed_arr,
  input  logic             load,
  input  logic             en,
  output logic [N-1:0]     q,
  output logic [NUM*N-1:0] lanes,
  output logic             q_valid,
  output logic             period_done
);

  // Lane state, seed computed from the live input, and seed captured at the last reset/load.
  logic [N-1:0] seed_calc [NUM];
  logic [N-1:0] seed_q    [NUM];
  logic [N-1:0] lane_q    [NUM];
  logic [N-1:0] lane_step [NUM];
  logic         q_valid_q;
  logic         period_done_q;

  // Per-lane seed: zero-extended seed base plus (lane index + 1), N-bit wrap.
  always_comb begin
    for (int i = 0; i < NUM; i++) begin
      seed_calc[i] = {{(N - NUM){1'b0}}, seed_arr} + N'(i + 1);
    end
  end

  // One LFSR step per lane. An all-zero lane (lock-up) reloads its captured seed instead.
  always_comb begin
    for (int i = 0; i < NUM; i++) begin
      if (lane_q[i] == '0) begin
        lane_step[i] = seed_q[i];
      end else begin
        lane_step[i] = {lane_q[i][N-2:0],
                        lane_q[i][31] ^ lane_q[i][21] ^ lane_q[i][1] ^ lane_q[i][0]};
      end
    end
  end

  // State update with priority reset > load > enable. Reset and load both reseed every lane.
  always_ff @(posedge clk) begin
    if (!reset_n || load) begin
      for (int i = 0; i < NUM; i++) begin
        lane_q[i] <= seed_calc[i];
        seed_q[i] <= seed_calc[i];
      end
      q_valid_q     <= 1'b0;
      period_done_q <= 1'b0;
    end else if (en) begin
      for (int i = 0; i < NUM; i++) begin
        lane_q[i] <= lane_step[i];
      end
      q_valid_q     <= 1'b1;
      period_done_q <= (lane_step[0] == seed_q[0]);
    end else begin
      period_done_q <= 1'b0;
    end
  end

  // Output word is the XOR reduction across lanes; lanes is a flat register view.
  always_comb begin
    q     = '0;
    lanes = '0;
    for (int i = 0; i < NUM; i++) begin
      q              = q ^ lane_q[i];
      lanes[i*N +: N] = lane_q[i];
    end
  end

  assign q_valid     = q_valid_q;
  assign period_done = period_done_q;

endmodule

// File: tb/tb_prng_generator.sv
// Directed bench for prng_generator: reset/load seeding, stepping, hold, mid-run reset,
// load-over-enable priority and a reference-model run of the XOR output word.
module tb_prng_generator;

  localparam int unsigned N   = 32;
  localparam int unsigned NUM = 3;

  logic             clk;
  logic             reset_n;
  logic [NUM-1:0]   seed_arr;
  logic             load;
  logic             en;
  logic [N-1:0]     q;
  logic [NUM*N-1:0] lanes;
  logic             q_valid;
  logic             period_done;

  int unsigned n_cmp;
  int unsigned n_err;

  logic [N-1:0] m_lane [NUM];

  prng_generator #(.N(N), .NUM(NUM)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .seed_arr    (seed_arr),
    .load        (load),
    .en          (en),
    .q           (q),
    .lanes       (lanes),
    .q_valid     (q_valid),
    .period_done (period_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [NUM*N-1:0] m_pack();
    logic [NUM*N-1:0] v;
    for (int i = 0; i < NUM; i++) v[i*N +: N] = m_lane[i];
    return v;
  endfunction

  function automatic logic [N-1:0] m_q();
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < NUM; i++) v = v ^ m_lane[i];
    return v;
  endfunction

  task automatic m_seed(input logic [NUM-1:0] base);
    for (int i = 0; i < NUM; i++) m_lane[i] = 32'(base) + 32'(i + 1);
  endtask

  task automatic m_step();
    for (int i = 0; i < NUM; i++) m_lane[i] = lfsr_next(m_lane[i]);
  endtask

  // Inputs change on the falling edge; the DUT is sampled on the following falling edge.
  initial begin
    n_cmp    = 0;
    n_err    = 0;
    reset_n  = 1'b0;
    seed_arr = '0;
    load     = 1'b0;
    en       = 1'b1;

    @(negedge clk);
    check_eq("reset_lanes", 128'(lanes), {32'd0, 32'd3, 32'd2, 32'd1});
    check_eq("reset_q", 128'(q), 128'd0);
    check_eq("reset_qvalid", 128'(q_valid), 128'd0);
    check_eq("reset_pdone", 128'(period_done), 128'd0);

    reset_n = 1'b1;
    @(negedge clk);
    check_eq("step1_lanes", 128'(lanes), {32'd0, 32'd6, 32'd5, 32'd3});
    check_eq("step1_q", 128'(q), 128'd0);
    check_eq("step1_qvalid", 128'(q_valid), 128'd1);
    @(negedge clk);
    check_eq("step2_lanes", 128'(lanes), {32'd0, 32'd13, 32'd11, 32'd6});
    check_eq("step2_q", 128'(q), 128'd0);

    // Load with en still high: load wins, no step.
    seed_arr = 3'b100;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check_eq("load_lanes", 128'(lanes), {32'd0, 32'd7, 32'd6, 32'd5});
    check_eq("load_q", 128'(q), 128'd4);
    check_eq("load_qvalid", 128'(q_valid), 128'd0);
    @(negedge clk);
    check_eq("load_step_lanes", 128'(lanes), {32'd0, 32'd14, 32'd13, 32'd11});
    check_eq("load_step_q", 128'(q), 128'd8);

    m_seed(3'b100);
    m_step();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      m_step();
    end
    check_eq("pre_hold_lanes", 128'(lanes), 128'(m_pack()));

    // Hold for 5 cycles; a seed change while holding must not matter.
    en       = 1'b0;
    seed_arr = 3'b011;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("hold_lanes", 128'(lanes), 128'(m_pack()));
      check_eq("hold_q", 128'(q), 128'(m_q()));
      check_eq("hold_pdone", 128'(period_done), 128'd0);
      check_eq("hold_qvalid", 128'(q_valid), 128'd1);
    end
    seed_arr = 3'b000;
    en       = 1'b1;
    @(negedge clk);
    m_step();
    check_eq("resume_lanes", 128'(lanes), 128'(m_pack()));

    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      m_step();
    end
    check_eq("run100_lanes", 128'(lanes), 128'(m_pack()));

    // Mid-run reset with en held high.
    reset_n = 1'b0;
    @(negedge clk);
    check_eq("midreset_lanes", 128'(lanes), {32'd0, 32'd3, 32'd2, 32'd1});
    check_eq("midreset_qvalid", 128'(q_valid), 128'd0);
    reset_n = 1'b1;
    m_seed(3'b000);

    // Reference-model run of the output word; lane 0 cannot return to its seed this soon.
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      m_step();
      check_eq("model_q", 128'(q), 128'(m_q()));
      check_eq("model_pdone", 128'(period_done), 128'd0);
    end
    check_eq("model_lanes", 128'(lanes), 128'(m_pack()));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
